// File: rtl/exmem_pipe_reg.sv
// EX->MEM pipeline stage register: valid/ready handshake, synchronous flush,
// optional 2-entry skid buffer, and forwarding/load-use info back to EX.
module exmem_pipe_reg #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned REG_IDX_WIDTH = 5,
  parameter int unsigned SKID          = 1,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(32'h8000_0000)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      PC_in,
  input  logic [ADDR_WIDTH-1:0]      Next_PC_in,
  input  logic [DATA_WIDTH-1:0]      ALU_in,
  input  logic [DATA_WIDTH-1:0]      reg_b_in,
  input  logic [REG_IDX_WIDTH-1:0]   rd_in,
  input  logic                       mem_re_in,
  input  logic                       mem_we_in,
  input  logic [DATA_WIDTH/8-1:0]    mem_sel_in,
  input  logic                       wb_en_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_WIDTH-1:0]      PC_out,
  output logic [ADDR_WIDTH-1:0]      Next_PC_out,
  output logic [DATA_WIDTH-1:0]      ALU_out,
  output logic [DATA_WIDTH-1:0]      reg_b_out,
  output logic [REG_IDX_WIDTH-1:0]   rd_out,
  output logic                       mem_re_out,
  output logic                       mem_we_out,
  output logic [DATA_WIDTH/8-1:0]    mem_sel_out,
  output logic                       wb_en_out,
  output logic                       fwd_valid,
  output logic [REG_IDX_WIDTH-1:0]   fwd_rd,
  output logic                       load_pending
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    pc;
    logic [ADDR_WIDTH-1:0]    next_pc;
    logic [DATA_WIDTH-1:0]    alu;
    logic [DATA_WIDTH-1:0]    reg_b;
    logic [REG_IDX_WIDTH-1:0] rd;
    logic                     mem_re;
    logic                     mem_we;
    logic [SEL_WIDTH-1:0]     mem_sel;
    logic                     wb_en;
  } entry_t;

  localparam entry_t RST_ENTRY = '{
    pc:      PC_ADDR,
    next_pc: PC_ADDR,
    alu:     '0,
    reg_b:   '0,
    rd:      '0,
    mem_re:  1'b0,
    mem_we:  1'b0,
    mem_sel: '0,
    wb_en:   1'b0
  };

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t state_q;
  entry_t head_q;
  entry_t skid_q;
  entry_t in_entry;
  logic   accept;
  logic   pop;

  always_comb begin
    in_entry         = RST_ENTRY;
    in_entry.pc      = PC_in;
    in_entry.next_pc = Next_PC_in;
    in_entry.alu     = ALU_in;
    in_entry.reg_b   = reg_b_in;
    in_entry.rd      = rd_in;
    in_entry.mem_re  = mem_re_in;
    in_entry.mem_we  = mem_we_in;
    in_entry.mem_sel = mem_sel_in;
    in_entry.wb_en   = wb_en_in;
  end

  // Skid build: in_ready comes straight from state; single-register build
  // lets a popping head take a new entry in the same cycle.
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (SKID != 0) ? (state_q != ST_TWO)
                                 : ((state_q == ST_EMPTY) | out_ready);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      head_q  <= RST_ENTRY;
      skid_q  <= RST_ENTRY;
    end else if (flush) begin
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            head_q  <= in_entry;
            state_q <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            head_q <= in_entry;
          end else if (accept) begin
            skid_q  <= in_entry;
            state_q <= ST_TWO;
          end else if (pop) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            head_q  <= skid_q;
            state_q <= ST_ONE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  // Control bits are gated so MEM never sees an access from a bubble.
  assign PC_out       = head_q.pc;
  assign Next_PC_out  = head_q.next_pc;
  assign ALU_out      = head_q.alu;
  assign reg_b_out    = head_q.reg_b;
  assign rd_out       = head_q.rd;
  assign mem_sel_out  = head_q.mem_sel;
  assign mem_re_out   = out_valid & head_q.mem_re;
  assign mem_we_out   = out_valid & head_q.mem_we;
  assign wb_en_out    = out_valid & head_q.wb_en;

  assign fwd_rd       = head_q.rd;
  assign fwd_valid    = out_valid & head_q.wb_en & ~head_q.mem_re & (head_q.rd != '0);
  assign load_pending = out_valid & head_q.mem_re & (head_q.rd != '0);

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Directed bench for exmem_pipe_reg: skid build for handshake/flush/forwarding,
// plus a single-register build for the combinational in_ready path.
module tb_exmem_pipe_reg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] pc_in, npc_in, alu_in, regb_in;
  logic [4:0]  rd_in;
  logic        re_in, we_in, wb_in;
  logic [3:0]  sel_in;

  logic        in_ready, out_valid, mem_re_o, mem_we_o, wb_en_o, fwd_valid, load_pending;
  logic [31:0] pc_o, npc_o, alu_o, regb_o;
  logic [4:0]  rd_o, fwd_rd;
  logic [3:0]  sel_o;

  logic        in_ready0, out_valid0, mem_re0, mem_we0, wb_en0, fwd_valid0, load_pending0;
  logic [31:0] pc0, npc0, alu0, regb0;
  logic [4:0]  rd0, fwd_rd0;
  logic [3:0]  sel0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  exmem_pipe_reg #(.SKID(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .PC_in(pc_in), .Next_PC_in(npc_in), .ALU_in(alu_in), .reg_b_in(regb_in), .rd_in(rd_in),
    .mem_re_in(re_in), .mem_we_in(we_in), .mem_sel_in(sel_in), .wb_en_in(wb_in),
    .out_valid(out_valid), .out_ready(out_ready), .PC_out(pc_o), .Next_PC_out(npc_o),
    .ALU_out(alu_o), .reg_b_out(regb_o), .rd_out(rd_o), .mem_re_out(mem_re_o),
    .mem_we_out(mem_we_o), .mem_sel_out(sel_o), .wb_en_out(wb_en_o),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .load_pending(load_pending)
  );

  exmem_pipe_reg #(.SKID(0)) dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .PC_in(pc_in), .Next_PC_in(npc_in), .ALU_in(alu_in), .reg_b_in(regb_in), .rd_in(rd_in),
    .mem_re_in(re_in), .mem_we_in(we_in), .mem_sel_in(sel_in), .wb_en_in(wb_in),
    .out_valid(out_valid0), .out_ready(out_ready), .PC_out(pc0), .Next_PC_out(npc0),
    .ALU_out(alu0), .reg_b_out(regb0), .rd_out(rd0), .mem_re_out(mem_re0),
    .mem_we_out(mem_we0), .mem_sel_out(sel0), .wb_en_out(wb_en0),
    .fwd_valid(fwd_valid0), .fwd_rd(fwd_rd0), .load_pending(load_pending0)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [4:0] rd, input logic re, input logic we, input logic wb);
    in_valid = v;
    pc_in    = pc;
    npc_in   = pc + 32'd4;
    alu_in   = alu;
    regb_in  = alu ^ 32'hFFFF_FFFF;
    rd_in    = rd;
    re_in    = re;
    we_in    = we;
    wb_in    = wb;
    sel_in   = 4'hF;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_pc", 64'(pc_o), 64'h8000_0000);
    check("rst_npc", 64'(npc_o), 64'h8000_0000);
    check("rst_mem_we", 64'(mem_we_o), 64'd0);
    rst_i = 1'b0;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // back-to-back stream
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h8000_0000 + 32'(4 * i), 32'h10 + 32'(i), 5'd1, 1'b0, 1'b0, 1'b1);
      tick();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_pc", 64'(pc_o), 64'(32'h8000_0000 + 32'(4 * i)));
      check("stream_alu", 64'(alu_o), 64'(32'h10 + 32'(i)));
    end
    check("stream_npc", 64'(npc_o), 64'h8000_0010);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("stream_drain", 64'(out_valid), 64'd0);
    check("drain_wb_gated", 64'(wb_en_o), 64'd0);

    // backpressure fills head then skid
    out_ready = 1'b0;
    drive(1'b1, 32'h100, 32'hA, 5'd2, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h200, 32'hB, 5'd3, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_head", 64'(pc_o), 64'h100);
    check("bp_we", 64'(mem_we_o), 64'd1);
    tick();
    check("bp_hold", 64'(pc_o), 64'h100);
    out_ready = 1'b1;
    tick();
    check("bp_second", 64'(pc_o), 64'h200);
    check("bp_second_v", 64'(out_valid), 64'd1);
    check("bp_second_alu", 64'(alu_o), 64'hB);
    tick();
    check("bp_empty", 64'(out_valid), 64'd0);

    // flush in TWO with an incoming entry
    out_ready = 1'b0;
    drive(1'b1, 32'h300, 32'h1, 5'd4, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h304, 32'h2, 5'd4, 1'b0, 1'b1, 1'b0);
    tick();
    check("fl_pre_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h308, 32'h3, 5'd4, 1'b0, 1'b1, 1'b0);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_we", 64'(mem_we_o), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    check("fl_lost", 64'(out_valid), 64'd0);

    // forwarding / load-use
    out_ready = 1'b0;
    drive(1'b1, 32'h400, 32'h1234, 5'd5, 1'b0, 1'b0, 1'b1);
    tick();
    check("fwd_valid", 64'(fwd_valid), 64'd1);
    check("fwd_rd", 64'(fwd_rd), 64'd5);
    check("fwd_alu", 64'(alu_o), 64'h1234);
    check("fwd_no_load", 64'(load_pending), 64'd0);
    out_ready = 1'b1;
    drive(1'b1, 32'h404, 32'h1234, 5'd5, 1'b1, 1'b0, 1'b1);
    tick();
    check("ld_fwd_valid", 64'(fwd_valid), 64'd0);
    check("ld_pending", 64'(load_pending), 64'd1);
    check("ld_re", 64'(mem_re_o), 64'd1);
    drive(1'b1, 32'h408, 32'h1234, 5'd0, 1'b1, 1'b0, 1'b1);
    tick();
    check("x0_fwd", 64'(fwd_valid), 64'd0);
    check("x0_pending", 64'(load_pending), 64'd0);
    drive(1'b1, 32'h40C, 32'h55, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check("x0_alu_fwd", 64'(fwd_valid), 64'd0);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("fwd_drain", 64'(out_valid), 64'd0);

    // mid-operation async reset
    out_ready = 1'b0;
    drive(1'b1, 32'h500, 32'h7, 5'd6, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    check("s0_head_stall", 64'(in_ready0), 64'd0);
    #2 rst_i = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_pc", 64'(pc_o), 64'h8000_0000);
    check("arst_valid0", 64'(out_valid0), 64'd0);
    tick();
    rst_i = 1'b0;
    tick();

    // single-register build: same-cycle stall and accept+pop
    drive(1'b1, 32'h600, 32'hC, 5'd7, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h604, 32'hD, 5'd7, 1'b0, 1'b0, 1'b1);
    #1;
    check("s0_head", 64'(pc0), 64'h600);
    check("s0_stall", 64'(in_ready0), 64'd0);
    out_ready = 1'b1;
    #1;
    check("s0_ready_comb", 64'(in_ready0), 64'd1);
    tick();
    check("s0_accept_pop", 64'(pc0), 64'h604);
    check("s0_valid", 64'(out_valid0), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("s0_empty", 64'(out_valid0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
